// File: rtl/disp_scan_controller.sv
// Multiplexed N-digit 7-segment scan driver with leading-zero blanking, PWM
// brightness and a frame-synchronous double-buffered data load.
module disp_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BRIGHT_BITS = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_blank,
  input  logic [BRIGHT_BITS-1:0]    brightness,
  input  logic                      load,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = BRIGHT_BITS + CW + 2;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  logic [CW-1:0]         scan_cnt_p0;
  logic [IW-1:0]         idx_p0;
  logic                  slot_end_p0;
  logic                  frame_end_p0;

  logic [DW-1:0]         pend_data;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_valid;
  logic [DW-1:0]         disp_data;
  logic [NUM_DIGITS-1:0] disp_dp;

  logic [NUM_DIGITS-1:0] blank_p0;
  logic                  zeros_above;
  logic [3:0]            nib_p0;
  logic                  dp_sel_p0;
  logic                  en_sel_p0;
  logic                  blank_sel_p0;
  logic [NUM_DIGITS-1:0] an_sel_p0;
  logic [PW-1:0]         on_limit_p0;
  logic                  vld_p0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // ---- stage p0: scan position (slot counter and digit index) ----
  assign slot_end_p0  = (scan_cnt_p0 == SCAN_LAST);
  assign frame_end_p0 = slot_end_p0 && (idx_p0 == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_p0 <= '0;
      idx_p0      <= '0;
    end else if (slot_end_p0) begin
      scan_cnt_p0 <= '0;
      idx_p0      <= frame_end_p0 ? '0 : idx_p0 + IW'(1);
    end else begin
      scan_cnt_p0 <= scan_cnt_p0 + CW'(1);
    end
  end

  // Display buffer only changes on the frame boundary; a load landing in that
  // very cycle bypasses pending so it is not delayed a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
    end else begin
      if (load) begin
        pend_data  <= data;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
      if (frame_end_p0) begin
        if (load) begin
          disp_data  <= data;
          disp_dp    <= dp_in;
          pend_valid <= 1'b0;
        end else if (pend_valid) begin
          disp_data  <= pend_data;
          disp_dp    <= pend_dp;
          pend_valid <= 1'b0;
        end
      end
    end
  end

  // A digit is a leading zero only while every digit above it is also zero.
  always_comb begin
    blank_p0    = '0;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i != 0 && lz_blank && disp_data[i*4 +: 4] == 4'h0 && !disp_dp[i] && zeros_above)
        blank_p0[i] = 1'b1;
      zeros_above = zeros_above && (disp_data[i*4 +: 4] == 4'h0);
    end
  end

  always_comb begin
    nib_p0       = '0;
    dp_sel_p0    = 1'b0;
    en_sel_p0    = 1'b0;
    blank_sel_p0 = 1'b0;
    an_sel_p0    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == IW'(i)) begin
        nib_p0       = disp_data[i*4 +: 4];
        dp_sel_p0    = disp_dp[i];
        en_sel_p0    = digit_en[i];
        blank_sel_p0 = blank_p0[i];
        an_sel_p0[i] = 1'b1;
      end
    end
  end

  // scan_cnt=0 is always dark so the previous digit's anode can discharge.
  assign on_limit_p0 = ((PW'(brightness) + PW'(1)) * PW'(SCAN_DIV)) >> BRIGHT_BITS;
  assign vld_p0      = (scan_cnt_p0 != '0) && (PW'(scan_cnt_p0) < on_limit_p0)
                       && en_sel_p0 && !blank_sel_p0;

  // ---- stage p1: registered pin drive with polarity applied ----
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= {7{POL}};
      dp         <= POL;
      an         <= {NUM_DIGITS{POL}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= {7{POL}} ^ (vld_p0 ? hex_to_seg(nib_p0) : 7'h00);
      dp         <= POL ^ (vld_p0 & dp_sel_p0);
      an         <= {NUM_DIGITS{POL}} ^ (vld_p0 ? an_sel_p0 : {NUM_DIGITS{1'b0}});
      frame_tick <= frame_end_p0;
    end
  end

endmodule

// File: tb/tb_disp_scan_controller.sv
// Bench for disp_scan_controller: frame-level reference model plus directed
// scenarios with hand-computed pin values.
module tb_disp_scan_controller;

  localparam int ND = 4;
  localparam int SD = 10;
  localparam int BB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   data = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    digit_en = 4'hF;
  logic          lz_blank = 1'b0;
  logic [BB-1:0] brightness = 2'd3;
  logic          load = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_tick;

  int errors = 0;
  int checks = 0;

  disp_scan_controller #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_BITS(BB), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .digit_en(digit_en),
    .lz_blank(lz_blank), .brightness(brightness), .load(load),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan is plain elapsed-cycle arithmetic.
  logic [6:0]  hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          pos;
  bit          model_ok = 1'b0;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  bit          m_pv;
  logic [12:0] exp_vec;

  always @(posedge clk) begin
    int slot, ph, lim, hi;
    bit last, on;
    logic [3:0] nib;
    logic [6:0] s;
    logic [3:0] a;
    if (rst) begin
      exp_vec  = {7'h7F, 1'b1, 4'hF, 1'b0};
      pos      = 0;
      m_disp   = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      slot = (pos / SD) % ND;
      ph   = pos % SD;
      last = (pos % (SD * ND)) == (SD * ND - 1);
      hi   = -1;
      for (int i = 0; i < ND; i++) if (m_disp[i*4 +: 4] != 4'h0) hi = i;
      nib  = m_disp[slot*4 +: 4];
      lim  = ((int'(brightness) + 1) * SD) >> BB;
      on   = (ph >= 1) && (ph < lim) && digit_en[slot]
             && !(lz_blank && slot != 0 && slot > hi && !m_dp[slot]);
      s = on ? hex7[nib] : 7'h00;
      a = on ? (4'b0001 << slot) : 4'b0000;
      exp_vec = {~s, ~(on & m_dp[slot]), ~a, last};
      if (load) begin m_pend = data; m_pdp = dp_in; m_pv = 1'b1; end
      if (last && m_pv) begin m_disp = m_pend; m_dp = m_pdp; m_pv = 1'b0; end
      pos++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if ({seg, dp, an, frame_tick} !== exp_vec) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model_cycle t=%0t got seg=%b dp=%b an=%b tick=%b exp seg=%b dp=%b an=%b tick=%b",
                   $time, seg, dp, an, frame_tick,
                   exp_vec[12:6], exp_vec[5], exp_vec[4:1], exp_vec[0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL frame_tick_timeout got=none exp=pulse");
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data = d; dp_in = p; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  // One full frame of samples following a tick sample.
  task automatic scan_frame(output int active, output int hi_lit, output int not_d0);
    active = 0; hi_lit = 0; not_d0 = 0;
    for (int i = 0; i < SD * ND; i++) begin
      @(negedge clk);
      if (an !== 4'hF) active++;
      if (an[3] !== 1'b1 || an[2] !== 1'b1) hi_lit++;
      if (an !== 4'hF && an !== 4'hE) not_d0++;
    end
  endtask

  initial begin
    int n, act, hil, nd0;
    bit seen;
    step(3);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1'b1);
    chk("reset_tick", frame_tick, 1'b0);
    rst = 1'b0;

    n = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); n++;
      if (frame_tick === 1'b1) begin seen = 1'b1; break; end
    end
    chk("first_tick_latency", seen ? n : 0, 40);

    do_load(16'h1234, 4'h0);
    wait_tick();
    step(2);
    chk("d0_an_1234", an, 4'b1110);
    chk("d0_seg_1234", seg, 7'b0011001);
    step(30);
    chk("d3_an_1234", an, 4'b0111);
    chk("d3_seg_1234", seg, 7'b1111001);

    brightness = 2'd0;
    wait_tick();
    scan_frame(act, hil, nd0);
    chk("active_bright0", act, 4);
    brightness = 2'd3;
    wait_tick();
    scan_frame(act, hil, nd0);
    chk("active_bright3", act, 36);

    lz_blank = 1'b1;
    do_load(16'h0045, 4'h0);
    wait_tick();
    scan_frame(act, hil, nd0);
    chk("lz_hi_digits_dark", hil, 0);
    chk("lz_active_0045", act, 18);
    do_load(16'h0000, 4'h0);
    wait_tick();
    step(2);
    chk("lz_zero_an", an, 4'b1110);
    chk("lz_zero_seg", seg, 7'b1000000);
    step(38);
    scan_frame(act, hil, nd0);
    chk("lz_zero_only_d0", nd0, 0);

    lz_blank = 1'b0;
    wait_tick();
    step(15);
    do_load(16'hABCD, 4'b0001);
    step(16);
    chk("mid_frame_d3_an", an, 4'b0111);
    chk("mid_frame_d3_old", seg, 7'b1000000);
    wait_tick();
    step(2);
    chk("abcd_d0_seg", seg, 7'b0100001);
    chk("abcd_d0_dp", dp, 1'b0);
    step(30);
    chk("abcd_d3_seg", seg, 7'b0001000);
    do_load(16'h1111, 4'h0);
    step(1);
    do_load(16'h2222, 4'h0);
    wait_tick();
    step(2);
    chk("two_loads_last_wins", seg, 7'b0100100);

    digit_en = 4'b1101;
    wait_tick();
    scan_frame(act, hil, nd0);
    chk("digit_en_active", act, 27);
    digit_en = 4'hF;

    wait_tick();
    step(3);
    do_load(16'h9999, 4'h0);
    step(6);
    rst = 1'b1;
    step(1);
    chk("midrst_an", an, 4'hF);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_tick", frame_tick, 1'b0);
    rst = 1'b0;
    wait_tick();
    step(2);
    chk("midrst_pending_lost", seg, 7'b1000000);
    chk("midrst_d0_an", an, 4'b1110);
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
